// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment driver: shadowed hex/dp/blank inputs,
// programmable slot length with a leading anti-ghost gap, optional leading-zero blanking.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                                                Clock,
    input  logic                                                Reset,
    input  logic [4*NUM_DIGITS-1:0]                             DataIn,
    input  logic [NUM_DIGITS-1:0]                               DpIn,
    input  logic [NUM_DIGITS-1:0]                               BlankIn,
    input  logic                                                Load,
    output logic [7:0]                                          Segments,
    output logic [NUM_DIGITS-1:0]                               Anodes,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] DigitIndex
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] data_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic [7:0]              seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic [IDX_W-1:0]        digit_idx_reg;

    logic [3:0]              nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dark;

    // A digit is dark when forced blank, or when it and every digit above it
    // hold zero (digit 0 always stays visible so the display never goes empty).
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble[gi] = data_reg[4*gi +: 4];
            if (LZ_SUPPRESS != 0 && gi != 0) begin : g_lz
                logic zero_above;
                assign zero_above = (data_reg[4*NUM_DIGITS-1:4*gi] == '0);
                assign dark[gi]   = blank_reg[gi] | zero_above;
            end else begin : g_no_lz
                assign dark[gi] = blank_reg[gi];
            end
        end
    endgenerate

    function automatic logic [6:0] decode_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (cnt_reg == CNT_LAST) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Outputs are built from pre-edge state, so a Load on this edge shows next cycle.
    always_comb begin
        an_next  = '1;
        seg_next = 8'hFF;
        if (cnt_reg >= BLANK_LIM && !dark[idx_reg]) begin
            an_next[idx_reg] = 1'b0;
            seg_next         = {decode_hex(nibble[idx_reg]), ~dp_reg[idx_reg]};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_reg       <= '0;
            idx_reg       <= '0;
            data_reg      <= '0;
            dp_reg        <= '0;
            blank_reg     <= '0;
            seg_reg       <= 8'hFF;
            an_reg        <= '1;
            digit_idx_reg <= '0;
        end else begin
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            seg_reg       <= seg_next;
            an_reg        <= an_next;
            digit_idx_reg <= idx_reg;
            if (Load) begin
                data_reg  <= DataIn;
                dp_reg    <= DpIn;
                blank_reg <= BlankIn;
            end
        end
    end

    assign Segments   = seg_reg;
    assign Anodes     = an_reg;
    assign DigitIndex = digit_idx_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboarded bench for seven_segment_scanner: a plain and a leading-zero-suppressing
// instance share stimulus; expected outputs come from a cycle-count model of the scan.
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic        Clock;
    logic        Reset, Load;
    logic [15:0] DataIn;
    logic [3:0]  DpIn, BlankIn;
    logic [7:0]  Segments, seg_lz;
    logic [3:0]  Anodes, an_lz;
    logic [1:0]  DigitIndex, idx_lz;

    seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(0)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DpIn(DpIn), .BlankIn(BlankIn), .Load(Load),
        .Segments(Segments), .Anodes(Anodes), .DigitIndex(DigitIndex));

    seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1)) dut_lz (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DpIn(DpIn), .BlankIn(BlankIn), .Load(Load),
        .Segments(seg_lz), .Anodes(an_lz), .DigitIndex(idx_lz));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int         cnt;
        int         idx;
        logic [1:0] didx;
        logic [3:0] an;
        logic [7:0] seg;
        logic [3:0] an_lz;
        logic [7:0] seg_lz;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          t     = 0;
    logic [15:0] sh_data  = '0;
    logic [3:0]  sh_dp    = '0;
    logic [3:0]  sh_blank = '0;

    logic [6:0] dec_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    function automatic void model(input int cnt, input int idx, input logic [15:0] d,
                                  input logic [3:0] dp, input logic [3:0] bl, input bit lz,
                                  output logic [3:0] an, output logic [7:0] seg);
        logic [15:0] above;
        above = d >> (4 * idx);
        an    = 4'hF;
        seg   = 8'hFF;
        if (cnt >= BC && !bl[idx] && !(lz && idx != 0 && above == 16'h0)) begin
            an[idx] = 1'b0;
            seg     = {dec_tab[above[3:0]], ~dp[idx]};
        end
    endfunction

    // Drive one cycle, push the output the next edge must produce, then wait past that edge.
    task automatic drive_cycle(input logic rst, input logic ld, input logic [15:0] d,
                               input logic [3:0] dp, input logic [3:0] bl);
        exp_t e;
        @(negedge Clock);
        Reset = rst; Load = ld; DataIn = d; DpIn = dp; BlankIn = bl;
        if (rst) begin
            e.cnt = -1; e.idx = 0; e.didx = 2'd0;
            e.an = 4'hF; e.seg = 8'hFF; e.an_lz = 4'hF; e.seg_lz = 8'hFF;
            t = 0; sh_data = '0; sh_dp = '0; sh_blank = '0;
        end else begin
            e.cnt  = t % RD;
            e.idx  = (t / RD) % ND;
            e.didx = 2'(e.idx);
            model(e.cnt, e.idx, sh_data, sh_dp, sh_blank, 1'b0, e.an, e.seg);
            model(e.cnt, e.idx, sh_data, sh_dp, sh_blank, 1'b1, e.an_lz, e.seg_lz);
            t++;
            if (ld) begin
                sh_data = d; sh_dp = dp; sh_blank = bl;
            end
        end
        sb_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total += 2;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL reset: got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                Anodes, Segments, DigitIndex, e.an, e.seg, e.didx);
            end
            if ({an_lz, seg_lz, idx_lz} !== {4'hF, 8'hFF, 2'd0}) begin
                bad++; $display("FAIL reset_lz: got an=%b seg=%b idx=%0d want an=1111 seg=11111111 idx=0",
                                an_lz, seg_lz, idx_lz);
            end
        end
        $display("test_reset: reset held 2 cycles");
    endtask

    task automatic test_scan();
        exp_t e;
        logic [7:0] lit [4] = '{8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, i == 0, 16'h1234, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total += 3;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL scan: cyc %0d got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                i, Anodes, Segments, DigitIndex, e.an, e.seg, e.didx);
            end
            if ({an_lz, seg_lz, idx_lz} !== {e.an_lz, e.seg_lz, e.didx}) begin
                bad++; $display("FAIL scan_lz: cyc %0d got an=%b seg=%b want an=%b seg=%b",
                                i, an_lz, seg_lz, e.an_lz, e.seg_lz);
            end
            if (e.cnt >= BC) begin
                if (Segments !== lit[e.idx] || Anodes !== ~(4'b0001 << e.idx)) begin
                    bad++; $display("FAIL scan_lit: cyc %0d got an=%b seg=%b want seg=%b", i, Anodes, Segments, lit[e.idx]);
                end
            end else if (Segments !== 8'hFF || Anodes !== 4'hF) begin
                bad++; $display("FAIL scan_gap: cyc %0d got an=%b seg=%b want 1111/11111111", i, Anodes, Segments);
            end
        end
        $display("test_scan: 1234 scanned for 20 cycles");
    endtask

    task automatic test_dp();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b0, 1'b1, 16'hABCD, 4'b0100, 4'h0);
            e = sb_q.pop_front();
            total += 2;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL dp: cyc %0d got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                i, Anodes, Segments, DigitIndex, e.an, e.seg, e.didx);
            end
            if ({an_lz, seg_lz} !== {e.an_lz, e.seg_lz}) begin
                bad++; $display("FAIL dp_lz: cyc %0d got an=%b seg=%b want an=%b seg=%b", i, an_lz, seg_lz, e.an_lz, e.seg_lz);
            end
            if (i >= 1 && e.cnt >= BC) begin
                total++;
                if (e.idx == 2 && Segments !== 8'b11000000) begin
                    bad++; $display("FAIL dp_lit: got seg=%b want 11000000", Segments);
                end else if (e.idx != 2 && Segments[0] !== 1'b1) begin
                    bad++; $display("FAIL dp_off: idx %0d got dp=%b want 1", e.idx, Segments[0]);
                end
            end
        end
        $display("test_dp: ABCD dp=0100 with Load held high");
    endtask

    task automatic test_lz();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            drive_cycle(1'b0, i == 0 || i == 16, (i < 16) ? 16'h0050 : 16'h0000, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total += 2;
            if ({an_lz, seg_lz, idx_lz} !== {e.an_lz, e.seg_lz, e.didx}) begin
                bad++; $display("FAIL lz: cyc %0d got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                i, an_lz, seg_lz, idx_lz, e.an_lz, e.seg_lz, e.didx);
            end
            if ({Anodes, Segments} !== {e.an, e.seg}) begin
                bad++; $display("FAIL lz_plain: cyc %0d got an=%b seg=%b want an=%b seg=%b", i, Anodes, Segments, e.an, e.seg);
            end
            if (i >= 1 && i != 16 && e.cnt >= BC) begin
                total++;
                if (e.idx >= 2 && an_lz !== 4'hF) begin
                    bad++; $display("FAIL lz_dark: idx %0d got an=%b want 1111", e.idx, an_lz);
                end else if (e.idx == 1 && i < 16 && seg_lz !== 8'b01001001) begin
                    bad++; $display("FAIL lz_five: got seg=%b want 01001001", seg_lz);
                end else if (e.idx == 1 && i > 16 && an_lz !== 4'hF) begin
                    bad++; $display("FAIL lz_zero_dark: got an=%b want 1111", an_lz);
                end else if (e.idx == 0 && {an_lz, seg_lz} !== {4'b1110, 8'b00000011}) begin
                    bad++; $display("FAIL lz_digit0: got an=%b seg=%b want 1110/00000011", an_lz, seg_lz);
                end
            end
        end
        $display("test_lz: 0050 then 0000 with suppression");
    endtask

    task automatic test_blank();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b0, i == 0, 16'h8888, 4'h0, 4'b1010);
            e = sb_q.pop_front();
            total += 2;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL blank: cyc %0d got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                i, Anodes, Segments, DigitIndex, e.an, e.seg, e.didx);
            end
            if (i >= 1 && (Anodes[1] !== 1'b1 || Anodes[3] !== 1'b1)) begin
                bad++; $display("FAIL blank_anode: cyc %0d got an=%b want bits 1,3 high", i, Anodes);
            end
            if (i >= 1 && e.cnt >= BC && (e.idx == 0 || e.idx == 2)) begin
                total++;
                if (Segments !== 8'b00000001) begin
                    bad++; $display("FAIL blank_eight: idx %0d got seg=%b want 00000001", e.idx, Segments);
                end
            end
        end
        $display("test_blank: 8888 with BlankIn=1010");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int k = 0; k < 16 && (t % 16) != 10; k++) begin
            drive_cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total++;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL midrst_pre: got an=%b seg=%b want an=%b seg=%b", Anodes, Segments, e.an, e.seg);
            end
        end
        drive_cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        e = sb_q.pop_front();
        total++;
        if ({Anodes, Segments, DigitIndex} !== {4'hF, 8'hFF, 2'd0}) begin
            bad++; $display("FAIL midrst: got an=%b seg=%b idx=%0d want 1111/11111111/0", Anodes, Segments, DigitIndex);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total += 2;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL midrst_post: cyc %0d got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                i, Anodes, Segments, DigitIndex, e.an, e.seg, e.didx);
            end
            if (i >= 1 && i <= 3 && {Anodes, Segments, DigitIndex} !== {4'b1110, 8'b00000011, 2'd0}) begin
                bad++; $display("FAIL midrst_digit0: cyc %0d got an=%b seg=%b want 1110/00000011", i, Anodes, Segments);
            end
        end
        $display("test_reset_mid: reset at cnt=2 idx=2");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_cycle(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
        void'(sb_q.pop_front());
        for (int k = 0; k < 16 && (t % 16) != 15; k++) begin
            drive_cycle(1'b0, 1'b0, 16'h1234, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total++;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL b2b_pre: got an=%b seg=%b want an=%b seg=%b", Anodes, Segments, e.an, e.seg);
            end
        end
        drive_cycle(1'b0, 1'b1, 16'h5678, 4'h0, 4'h0);
        e = sb_q.pop_front();
        total++;
        if ({Anodes, Segments, DigitIndex} !== {4'b0111, 8'b10011111, 2'd3}) begin
            bad++; $display("FAIL b2b_wrap: got an=%b seg=%b idx=%0d want 0111/10011111/3", Anodes, Segments, DigitIndex);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            e = sb_q.pop_front();
            total += 2;
            if ({Anodes, Segments, DigitIndex} !== {e.an, e.seg, e.didx}) begin
                bad++; $display("FAIL b2b: cyc %0d got an=%b seg=%b idx=%0d want an=%b seg=%b idx=%0d",
                                i, Anodes, Segments, DigitIndex, e.an, e.seg, e.didx);
            end
            if (i >= 1 && i <= 3 && {Anodes, Segments} !== {4'b1110, 8'b00000001}) begin
                bad++; $display("FAIL b2b_new: cyc %0d got an=%b seg=%b want 1110/00000001", i, Anodes, Segments);
            end
        end
        $display("test_back_to_back: load 5678 on slot wrap");
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; DataIn = '0; DpIn = '0; BlankIn = '0;
        test_reset();
        test_scan();
        test_dp();
        test_lz();
        test_blank();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
